// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame field layout, register range and the
// controller state encoding used by both ends of the link.
package spi_pkg;

  localparam int   ADDR_W      = 7;
  localparam int   DATA_W      = 8;
  localparam logic RW_WRITE    = 1'b1;
  localparam int   MAX_ADDRESS = 4;

  // A frame is the R/W bit, the address and the data field, MSB first.
  function automatic int frame_width(input int data_w);
    return 1 + ADDR_W + data_w;
  endfunction

  localparam int FRAME_W  = frame_width(DATA_W);
  localparam int RW_POS   = FRAME_W - 1;
  localparam int ADDR_MSB = FRAME_W - 2;
  localparam int ADDR_LSB = DATA_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/spi_controller_if.sv
// Request-side bundle between on-chip logic (master) and the SPI
// controller (slave), including the status outputs.
interface spi_controller_if #(
  parameter int W = 8
) ();
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [W-1:0]      req_data;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready, busy, done
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready, busy, done
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK phase timing: counts HALF_PERIOD clk cycles per phase, holds the
// SCLK level and flags the cycle before each rising or falling transition.
module spi_sclk_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic toggle_en,
  output logic phase_end,
  output logic rise,
  output logic fall,
  output logic sclk_level
);

  localparam int              PH_W    = $clog2(HALF_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

  logic [PH_W-1:0] phase_cnt_q, phase_cnt_d;
  logic            level_q, level_d;

  assign phase_end  = (phase_cnt_q == PH_LAST);
  assign rise       = phase_end && toggle_en && !level_q;
  assign fall       = phase_end && toggle_en && level_q;
  assign sclk_level = level_q;

  // Advance the phase counter and flip SCLK at the end of an enabled phase.
  always_comb begin
    phase_cnt_d = phase_cnt_q + PH_W'(1);
    level_d     = level_q;
    if (clear) begin
      phase_cnt_d = '0;
      level_d     = 1'b0;
    end else begin
      if (phase_end) begin
        phase_cnt_d = '0;
      end
      if (phase_end && toggle_en) begin
        level_d = !level_q;
      end
    end
  end

  // Phase counter and SCLK level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_cnt_q <= '0;
      level_q     <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      level_q     <= level_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Write-side SPI controller (mode 0): serialises one request at a time into
// an R/W + address + data frame on SCLK/nCS/COPI, then holds nCS high for
// CS_GAP cycles before signalling done. All pin outputs are registered.
module spi_controller
  import spi_pkg::*;
#(
  parameter int W           = 8,
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  req,
  output logic             SCLK,
  output logic             nCS,
  output logic             COPI
);

  localparam int FW    = frame_width(W);
  localparam int BIT_W = $clog2(FW);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(FW - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_SETUP = SETUP;
  localparam logic [2:0] S_SHIFT = SHIFT;
  localparam logic [2:0] S_HOLD  = HOLD;
  localparam logic [2:0] S_GAP   = GAP;

  if (HALF_PERIOD < 4) begin : g_bad_half_period
    $error("spi_controller: HALF_PERIOD must be at least 4");
  end
  if (CS_GAP < 4) begin : g_bad_cs_gap
    $error("spi_controller: CS_GAP must be at least 4");
  end

  logic [2:0]       state_q, state_d;
  logic [FW-1:0]    shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             ncs_q, ncs_d;
  logic             copi_q, copi_d;
  logic             done_q, done_d;

  logic req_ready_int;
  logic accept;
  logic active_d;
  logic toggle_en;
  logic phase_end;
  logic rise;
  logic fall;
  logic sclk_level;

  assign req_ready_int = (state_q == S_IDLE) && rst_n;
  assign accept        = req.req_valid && req_ready_int;

  assign req.req_ready = req_ready_int;
  assign req.busy      = (state_q != S_IDLE);
  assign req.done      = done_q;

  assign SCLK = sclk_level;
  assign nCS  = ncs_q;
  assign COPI = copi_q;

  // SCLK toggles out of SETUP and within SHIFT, except after the last bit's low phase.
  assign toggle_en = (state_q == S_SETUP) ||
                     ((state_q == S_SHIFT) && (sclk_level || (bit_cnt_q != '0)));

  spi_sclk_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_q == S_IDLE),
    .toggle_en  (toggle_en),
    .phase_end  (phase_end),
    .rise       (rise),
    .fall       (fall),
    .sclk_level (sclk_level)
  );

  // Frame sequencing: latch on acceptance, shift on each SCLK fall, then hold and gap.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = '0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = {req.req_rw, req.req_addr, req.req_data};
          bit_cnt_d = BIT_FIRST;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fall) begin
          shift_d = {shift_q[FW-2:0], 1'b0};
        end
        if (rise) begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end
        if (phase_end && !sclk_level && (bit_cnt_q == '0)) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin values follow the next state so nCS/COPI line up with the state change.
  always_comb begin
    active_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
    ncs_d    = !active_d;
    copi_d   = active_d ? shift_d[FW-1] : 1'b0;
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: three instances with different
// timing parameters, a cycle-indexed waveform model and a register model
// of the receiving peripheral fed from the sampled COPI bits.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [2:0] valid_a, rw_a;
  logic [6:0] addr_a [3];
  logic [7:0] data_a [3];
  logic [2:0] sclk_a, ncs_a, copi_a, ready_a, busy_a, done_a;

  spi_controller_if #(.W(8)) if0 ();
  spi_controller_if #(.W(8)) if1 ();
  spi_controller_if #(.W(8)) if2 ();

  assign if0.req_valid = valid_a[0];
  assign if0.req_rw    = rw_a[0];
  assign if0.req_addr  = addr_a[0];
  assign if0.req_data  = data_a[0];
  assign if1.req_valid = valid_a[1];
  assign if1.req_rw    = rw_a[1];
  assign if1.req_addr  = addr_a[1];
  assign if1.req_data  = data_a[1];
  assign if2.req_valid = valid_a[2];
  assign if2.req_rw    = rw_a[2];
  assign if2.req_addr  = addr_a[2];
  assign if2.req_data  = data_a[2];

  assign ready_a = {if2.req_ready, if1.req_ready, if0.req_ready};
  assign busy_a  = {if2.busy, if1.busy, if0.busy};
  assign done_a  = {if2.done, if1.done, if0.done};

  spi_controller #(.W(8), .HALF_PERIOD(4), .CS_GAP(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(if0),
    .SCLK(sclk_a[0]), .nCS(ncs_a[0]), .COPI(copi_a[0]));
  spi_controller #(.W(8), .HALF_PERIOD(4), .CS_GAP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(if1),
    .SCLK(sclk_a[1]), .nCS(ncs_a[1]), .COPI(copi_a[1]));
  spi_controller #(.W(8), .HALF_PERIOD(7), .CS_GAP(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(if2),
    .SCLK(sclk_a[2]), .nCS(ncs_a[2]), .COPI(copi_a[2]));

  int n_checks = 0;
  int n_fail   = 0;
  int hp_of  [3] = '{4, 4, 7};
  int gap_of [3] = '{8, 4, 4};

  logic [7:0] peri_regs [3][5];
  logic [7:0] exp_regs  [3][5];
  int frames_sent [3] = '{0, 0, 0};
  int done_cnt    [3] = '{0, 0, 0};
  int dbl_done = 0;
  logic [2:0] prev_done = 3'b000;
  int cyc = 0;

  logic obs_sclk [0:511];
  logic obs_ncs  [0:511];
  logic obs_copi [0:511];

  // Free-running cycle index used to measure spacing between frames.
  always @(posedge clk) cyc <= cyc + 1;

  // Count done pulses per instance and flag any pulse longer than one cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_a[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (done_a[i] && prev_done[i]) dbl_done <= dbl_done + 1;
    end
    prev_done <= done_a;
  end

  // Send one request on instance idx and check the whole frame against the timing model.
  task automatic do_frame(input int idx, input logic rw, input logic [6:0] addr,
                          input logic [7:0] data, input bit hold_next, input logic nrw,
                          input logic [6:0] naddr, input logic [7:0] ndata,
                          output int fall_abs, output int rise_abs);
    int h, g, budget, dcyc, last, nr, sclk_err, ncs_err, copi_err, low_cnt, k;
    logic [15:0] frame, decoded;
    logic exp_s, exp_n, exp_c;
    h = hp_of[idx];
    g = gap_of[idx];
    budget = 34 * h + g + 20;
    frame = {rw, addr, data};
    dcyc = -1;
    fall_abs = -1;
    rise_abs = -1;
    valid_a[idx] = 1'b1;
    rw_a[idx]    = rw;
    addr_a[idx]  = addr;
    data_a[idx]  = data;
    #1;
    n_checks++;
    if (ready_a[idx] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_before_accept dut%0d: got %b want 1", idx, ready_a[idx]);
    end
    @(posedge clk);
    frames_sent[idx]++;
    if (rw == 1'b1 && addr <= 7'd4) exp_regs[idx][addr] = data;
    for (int c = 1; c <= budget && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        fall_abs = cyc;
        if (hold_next) begin
          rw_a[idx]   = nrw;
          addr_a[idx] = naddr;
          data_a[idx] = ndata;
        end else begin
          valid_a[idx] = 1'b0;
          rw_a[idx]    = 1'($urandom);
          addr_a[idx]  = 7'($urandom);
          data_a[idx]  = 8'($urandom);
        end
      end
      obs_sclk[c] = sclk_a[idx];
      obs_ncs[c]  = ncs_a[idx];
      obs_copi[c] = copi_a[idx];
      if (rise_abs < 0 && c > 1 && ncs_a[idx] === 1'b1 && obs_ncs[c-1] === 1'b0) rise_abs = cyc;
      if (c == 5) begin
        n_checks++;
        if ({busy_a[idx], ready_a[idx]} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL busy_mid_frame dut%0d: busy,ready got %b%b want 10",
                   idx, busy_a[idx], ready_a[idx]);
        end
      end
      if (done_a[idx] === 1'b1) dcyc = c;
    end
    n_checks++;
    if (dcyc !== 1 + 34 * h + g) begin
      n_fail++;
      $display("[TB] FAIL done_cycle dut%0d: got %0d want %0d (-1 = timeout)", idx, dcyc, 1 + 34 * h + g);
    end
    last = (dcyc > 0) ? dcyc : budget;
    sclk_err = 0; ncs_err = 0; copi_err = 0; low_cnt = 0;
    for (int c = 1; c <= last; c++) begin
      exp_s = (c >= 1 + h) && (c <= 32 * h) && (((c - 1 - h) % (2 * h)) < h);
      exp_n = !(c <= 34 * h);
      if (obs_sclk[c] !== exp_s) sclk_err++;
      if (obs_ncs[c] !== exp_n) ncs_err++;
      if (obs_ncs[c] === 1'b0) low_cnt++;
      if (c <= 32 * h) begin
        k = 15 - (c - 1) / (2 * h);
        exp_c = frame[k];
        if (obs_copi[c] !== exp_c) copi_err++;
      end else if (c > 34 * h) begin
        if (obs_copi[c] !== 1'b0) copi_err++;
      end
    end
    nr = 0;
    decoded = '0;
    for (int c = 2; c <= last; c++) begin
      if (obs_sclk[c] === 1'b1 && obs_sclk[c-1] === 1'b0) begin
        decoded = {decoded[14:0], obs_copi[c]};
        nr++;
      end
    end
    n_checks++;
    if (sclk_err != 0) begin
      n_fail++;
      $display("[TB] FAIL sclk_wave dut%0d: got %0d bad cycles want 0", idx, sclk_err);
    end
    n_checks++;
    if (ncs_err != 0) begin
      n_fail++;
      $display("[TB] FAIL ncs_wave dut%0d: got %0d bad cycles want 0", idx, ncs_err);
    end
    n_checks++;
    if (copi_err != 0) begin
      n_fail++;
      $display("[TB] FAIL copi_stable dut%0d: got %0d bad cycles want 0", idx, copi_err);
    end
    n_checks++;
    if (low_cnt != 34 * h) begin
      n_fail++;
      $display("[TB] FAIL ncs_low_len dut%0d: got %0d want %0d", idx, low_cnt, 34 * h);
    end
    n_checks++;
    if (nr != 16 || decoded !== frame) begin
      n_fail++;
      $display("[TB] FAIL frame_bits dut%0d: got %0d rises data %h want 16 rises data %h",
               idx, nr, decoded, frame);
    end
    if (nr == 16 && decoded[15] == 1'b1 && decoded[14:8] <= 7'd4)
      peri_regs[idx][decoded[14:8]] = decoded[7:0];
  endtask

  // Outputs of every instance while reset is held, then ready after release.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({sclk_a[i], ncs_a[i], copi_a[i], busy_a[i], done_a[i], ready_a[i]} !== 6'b010000) begin
        n_fail++;
        $display("[TB] FAIL reset_values dut%0d: got %b want 010000", i,
                 {sclk_a[i], ncs_a[i], copi_a[i], busy_a[i], done_a[i], ready_a[i]});
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ready_a !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL ready_after_reset: got %b want 111", ready_a);
    end
    @(negedge clk);
  endtask

  // A single write with the default timing lands in the peripheral model.
  task automatic test_single_write();
    int f, r;
    do_frame(0, 1'b1, 7'h02, 8'hA5, 1'b0, 1'b0, 7'h0, 8'h0, f, r);
    n_checks++;
    if (peri_regs[0][2] !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL single_write_reg: got %h want a5", peri_regs[0][2]);
    end
  endtask

  // A request held valid during a frame waits for done and starts one cycle later.
  task automatic test_busy_ignore();
    int f1, r1, f2, r2;
    do_frame(0, 1'b1, 7'h01, 8'h5A, 1'b1, 1'b1, 7'h03, 8'h3C, f1, r1);
    do_frame(0, 1'b1, 7'h03, 8'h3C, 1'b0, 1'b0, 7'h0, 8'h0, f2, r2);
    n_checks++;
    if (f2 - r1 != gap_of[0] + 1) begin
      n_fail++;
      $display("[TB] FAIL ncs_gap_b2b: got %0d want %0d", f2 - r1, gap_of[0] + 1);
    end
    n_checks++;
    if (peri_regs[0][1] !== 8'h5A || peri_regs[0][3] !== 8'h3C) begin
      n_fail++;
      $display("[TB] FAIL busy_regs: got %h %h want 5a 3c", peri_regs[0][1], peri_regs[0][3]);
    end
  endtask

  // Addresses beyond the register range are still transmitted and completed.
  task automatic test_out_of_range();
    int f, r, bad;
    logic [7:0] snap [5];
    for (int a = 0; a < 5; a++) snap[a] = peri_regs[0][a];
    do_frame(0, 1'b0, 7'h7F, 8'hFF, 1'b0, 1'b0, 7'h0, 8'h0, f, r);
    bad = 0;
    for (int a = 0; a < 5; a++) if (peri_regs[0][a] !== snap[a]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL oor_regs_changed: got %0d changed want 0", bad);
    end
  endtask

  // Random requests on the default instance, then compare the register model.
  task automatic test_random();
    int f, r;
    for (int n = 0; n < 6; n++) begin
      do_frame(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom),
               1'b0, 1'b0, 7'h0, 8'h0, f, r);
    end
    for (int a = 0; a < 5; a++) begin
      n_checks++;
      if (peri_regs[0][a] !== exp_regs[0][a]) begin
        n_fail++;
        $display("[TB] FAIL random_reg%0d: got %h want %h", a, peri_regs[0][a], exp_regs[0][a]);
      end
    end
  endtask

  // Reset in the middle of a frame abandons it; a fresh write then completes.
  task automatic test_mid_reset();
    int f, r;
    valid_a[0] = 1'b1;
    rw_a[0]    = 1'b1;
    addr_a[0]  = 7'h02;
    data_a[0]  = 8'h77;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) valid_a[0] = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sclk_a[0], ncs_a[0], copi_a[0], busy_a[0], done_a[0], ready_a[0]} !== 6'b010000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_outputs: got %b want 010000",
               {sclk_a[0], ncs_a[0], copi_a[0], busy_a[0], done_a[0], ready_a[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ready_a[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_ready: got %b want 1", ready_a[0]);
    end
    repeat (5) @(negedge clk);
    do_frame(0, 1'b1, 7'h04, 8'h11, 1'b0, 1'b0, 7'h0, 8'h0, f, r);
    n_checks++;
    if (peri_regs[0][4] !== 8'h11) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_write: got %h want 11", peri_regs[0][4]);
    end
  endtask

  // Other timing parameters: fill all five registers with distinct values.
  task automatic test_param_sweep();
    int f, r, base;
    for (int idx = 1; idx < 3; idx++) begin
      base = $urandom_range(0, 255);
      for (int a = 0; a < 5; a++) begin
        do_frame(idx, 1'b1, 7'(a), 8'(base + a * 51), 1'b0, 1'b0, 7'h0, 8'h0, f, r);
      end
      for (int a = 0; a < 5; a++) begin
        n_checks++;
        if (peri_regs[idx][a] !== exp_regs[idx][a]) begin
          n_fail++;
          $display("[TB] FAIL sweep_dut%0d_reg%0d: got %h want %h", idx, a,
                   peri_regs[idx][a], exp_regs[idx][a]);
        end
      end
    end
  endtask

  // Every accepted and completed frame produced exactly one single-cycle done.
  task automatic test_done_pulses();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (done_cnt[i] != frames_sent[i]) begin
        n_fail++;
        $display("[TB] FAIL done_count dut%0d: got %0d want %0d", i, done_cnt[i], frames_sent[i]);
      end
    end
    n_checks++;
    if (dbl_done != 0) begin
      n_fail++;
      $display("[TB] FAIL done_width: got %0d long pulses want 0", dbl_done);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_a = '0;
    rw_a    = '0;
    for (int i = 0; i < 3; i++) begin
      addr_a[i] = '0;
      data_a[i] = '0;
      for (int a = 0; a < 5; a++) begin
        peri_regs[i][a] = '0;
        exp_regs[i][a]  = '0;
      end
    end
    test_reset();
    test_single_write();
    test_busy_ignore();
    test_out_of_range();
    test_random();
    test_mid_reset();
    test_param_sweep();
    test_done_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

Write-side SPI controller that serialises register-write requests from on-chip logic into 16-bit SPI frames (R/W bit, 7-bit address, W-bit data, MSB first) on SCLK/nCS/COPI. It is the transmitting end of the link that drives `spi_peripheral` and its configuration registers. Mode 0 only: SCLK idles low and COPI is stable around each SCLK rising edge. Edges are slow enough for a receiver that oversamples SCLK through a 2-flop synchroniser.

## Interface
- `W`, 8, data field width; frame width is 1 + 7 + W.
- `HALF_PERIOD`, 4, clk cycles per SCLK phase (high or low); legal values are ≥ 4, and an out-of-range value is an elaboration error.
- `CS_GAP`, 8, clk cycles nCS is held high after each frame; legal values are ≥ 4.

- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_rw`  in  1  R/W bit sent first in the frame; 1 means write.
- `req_addr`  in  7  register address.
- `req_data`  in  W  register data.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when a frame, including its CS gap, completes.
- `SCLK`  out  1  serial clock.
- `nCS`  out  1  chip select, active-low.
- `COPI`  out  1  serial data out.

## Operation
- **Reset values:** SCLK=0, nCS=1, COPI=0, busy=0, done=0, req_ready=0. State is IDLE and the shift register and counters are cleared.
- **Handshake:** a request is accepted in any cycle with `req_valid && req_ready`. `req_ready` = (state==IDLE) && rst_n.
  - On acceptance, {req_rw, req_addr, req_data} is latched into a 16-bit shift register; later input changes have no effect.
  - `req_valid` while busy is ignored. No queueing.
- **States:**
  - IDLE → SETUP on acceptance.
  - SETUP: nCS=0, COPI=frame[15], SCLK=0, for HALF_PERIOD cycles → SHIFT.
  - SHIFT: 16 bits. Each bit is HALF_PERIOD cycles SCLK=1, then HALF_PERIOD cycles SCLK=0.
    - COPI updates to the next bit on the SCLK falling transition.
    - After the 16th low phase → HOLD.
  - HOLD: SCLK=0, nCS=0, HALF_PERIOD cycles → GAP.
  - GAP: nCS=1, COPI=0, CS_GAP cycles → IDLE.
  - done=1 for exactly the first IDLE cycle.
- **Address range:** the controller does not filter addresses. Addresses above 4 are transmitted unchanged, and dropping them is the receiver's job.
- **Back-to-back:** a new request may be accepted in the same cycle `done` is high. The next frame's nCS falls one cycle later, so nCS high time is CS_GAP+1 cycles.
- **Reset mid-frame:** on the next clk edge with rst_n=0, outputs return to reset values and the frame is abandoned. No `done` pulse is produced.
- **Counters:** a phase counter of width $clog2(HALF_PERIOD) wraps from HALF_PERIOD-1 to 0. A bit counter counts 15 down to 0. The gap counter is $clog2(CS_GAP+1) wide.

## Timing
- All outputs are registered; there is no combinational path from `req_*` to SCLK/nCS/COPI.
- Latencies, with the acceptance cycle as cycle 0:
  - nCS falls at cycle 1, and COPI=bit 15 at cycle 1.
  - First SCLK rise at cycle 1+HALF_PERIOD.
  - Rise of bit k (k=15..0) at cycle 1 + HALF_PERIOD + 2·HALF_PERIOD·(15−k).
  - nCS rises at cycle 1 + 34·HALF_PERIOD.
  - `done` at cycle 1 + 34·HALF_PERIOD + CS_GAP; with defaults, nCS rises at cycle 137 and `done` is at cycle 145.
- COPI is stable for at least HALF_PERIOD cycles before and after every SCLK rise.

## Structure
- **Shared package `spi_pkg`:**
  - ADDR_W=7, FRAME_W derivation, RW_WRITE=1'b1, MAX_ADDRESS=4.
  - The controller state enum (IDLE, SETUP, SHIFT, HOLD, GAP), shared with the peripheral's field layout constants.
- **Sub-module `spi_sclk_gen`:** the phase counter, emitting `phase_end`, `rise` and `fall` strobes, with clear tied to IDLE. The FSM and shifter stay in the top.

## Test plan
- **Single write, defaults:** rw=1, addr=0x02, data=0xA5 → COPI samples at the SCLK rises are 1,0000010,10100101. nCS low for exactly 136 cycles. `done` at cycle 145. A connected `spi_peripheral` shows reg_0x02=0xA5.
- **Busy ignore:** a second request with data 0x3C is held valid during a frame → it is not accepted until the `done` cycle. It is then sent with nCS high for exactly 9 cycles between frames.
- **Out-of-range address:** addr=0x7F, rw=0, data=0xFF → the frame is transmitted bit-exact. The peripheral registers are unchanged, and `done` still pulses.
- **Mid-frame reset:** rst_n=0 at cycle 60 of a frame → the next edge gives nCS=1, SCLK=0, COPI=0, no `done`. After release, req_ready=1 and a fresh write to addr 0x04=0x11 completes correctly.
- **Parameter sweep:** HALF_PERIOD=4 and 7, CS_GAP=4 → the latency formulas hold exactly, and the loopback into the peripheral writes all of regs 0x00–0x04 with distinct values.
